// File: rtl/ay_bus_master.sv
// ay_bus_master
//   Bus initiator for an AY-style two-step register interface. Commands
//   (register write or read) arrive on a valid/ready port and are buffered in a
//   small FIFO. A sequencer then issues an address-latch tick (a0=0) followed
//   by a data tick (a0=1), with GAP idle cycles after every tick. Read results
//   return on a one-cycle response strobe.
//
//   Parameters
//     FIFO_DEPTH  command FIFO entries (power of two, >= 2)
//     GAP         idle cycles after every tick (>= 1)
//
//   Optional feature macro: AY_ADDR_CACHE_EN
//     When defined, the last latched address is remembered. A command that
//     targets the same register skips the address tick and its gap.
//
//   Ports
//     clk, reset         clock, synchronous active-high reset
//     cmd_valid/ready    command handshake; ready = FIFO not full
//     cmd_rd/addr/data   1=read / register number / write data
//     rsp_valid/data     read response pulse / held read result
//     busy               FIFO non-empty or sequencer active
//     ay_a0              0=address latch, 1=data transfer (held between ticks)
//     ay_wr_tick/wdata   write strobe / write data (held between ticks)
//     ay_rd_tick         read strobe
//     ay_rdata           read data, valid the cycle after ay_rd_tick
module ay_bus_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP        = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rd,
   input  logic [3:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       ay_a0,
   output logic       ay_wr_tick,
   output logic [7:0] ay_wdata,
   output logic       ay_rd_tick,
   input  logic [7:0] ay_rdata
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WAIT1, S_XFER, S_CAPT, S_WAIT2
   } state_t;

   typedef struct packed {
      logic       rd;
      logic [3:0] addr;
      logic [7:0] data;
   } cmd_t;

   state_t          state_q, state_d;
   cmd_t            cmd_q, cmd_d;
   cmd_t            fifo_mem [FIFO_DEPTH];
   cmd_t            head;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic            a0_q, a0_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic            push, pop, empty, gap_last, hit;

   assign empty     = (count_q == '0);
   assign cmd_ready = (count_q != CW'(FIFO_DEPTH));
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state_q == S_IDLE) & ~empty;
   assign head      = fifo_mem[rd_ptr_q];
   assign gap_last  = (gap_q == GW'(GAP - 1));
   assign busy      = ~empty | (state_q != S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

`ifdef AY_ADDR_CACHE_EN
   logic       cache_vld_q, cache_vld_d;
   logic [3:0] cache_addr_q, cache_addr_d;

   // The cache tracks the register the chip currently has latched.
   always_comb begin
      cache_vld_d  = cache_vld_q;
      cache_addr_d = cache_addr_q;
      if (state_q == S_ADDR) begin
         cache_vld_d  = 1'b1;
         cache_addr_d = cmd_q.addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cache_vld_q  <= 1'b0;
         cache_addr_q <= 4'h0;
      end else begin
         cache_vld_q  <= cache_vld_d;
         cache_addr_q <= cache_addr_d;
      end
   end

   assign hit = cache_vld_q & (cache_addr_q == head.addr);
`else
   assign hit = 1'b0;
`endif

   // FIFO bookkeeping; simultaneous push and pop leave the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= '{rd: cmd_rd, addr: cmd_addr, data: cmd_data};
   end

   // State register and all other flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         gap_q       <= '0;
         a0_q        <= 1'b0;
         wdata_q     <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         gap_q       <= gap_d;
         a0_q        <= a0_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      gap_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               cmd_d   = head;
               state_d = hit ? S_XFER : S_ADDR;
            end
         end
         S_ADDR: state_d = S_WAIT1;
         S_WAIT1: begin
            if (gap_last) state_d = S_XFER;
            else          gap_d   = gap_q + GW'(1);
         end
         S_XFER: state_d = cmd_q.rd ? S_CAPT : S_WAIT2;
         S_CAPT: state_d = S_WAIT2;
         S_WAIT2: begin
            if (gap_last) state_d = S_IDLE;
            else          gap_d   = gap_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs. a0/wdata show the new value during a tick and hold it afterwards.
   always_comb begin
      ay_wr_tick  = 1'b0;
      ay_rd_tick  = 1'b0;
      ay_a0       = a0_q;
      ay_wdata    = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         S_ADDR: begin
            ay_wr_tick = 1'b1;
            ay_a0      = 1'b0;
            ay_wdata   = {4'h0, cmd_q.addr};
         end
         S_XFER: begin
            ay_a0 = 1'b1;
            if (cmd_q.rd) begin
               ay_rd_tick = 1'b1;
            end else begin
               ay_wr_tick = 1'b1;
               ay_wdata   = cmd_q.data;
            end
         end
         S_CAPT: begin
            rsp_data_d  = ay_rdata;
            rsp_valid_d = 1'b1;
         end
         default: ;
      endcase
      a0_d    = ay_a0;
      wdata_d = ay_wdata;
   end

endmodule

// File: tb/tb_ay_bus_master.sv
module tb_ay_bus_master;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_rd;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       cmd_ready, rsp_valid, busy, ay_a0, ay_wr_tick, ay_rd_tick;
   logic [7:0] rsp_data, ay_wdata;
   logic [7:0] ay_rdata;

   // second instance with GAP=3
   logic       g3_cmd_valid, g3_cmd_rd;
   logic [3:0] g3_cmd_addr;
   logic [7:0] g3_cmd_data;
   logic       g3_cmd_ready, g3_rsp_valid, g3_busy, g3_a0, g3_wr, g3_rd;
   logic [7:0] g3_rsp_data, g3_wdata;
   logic [7:0] g3_rdata;

   always #5 clk = ~clk;

   ay_bus_master #(.FIFO_DEPTH(4), .GAP(1)) u_dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .ay_a0(ay_a0), .ay_wr_tick(ay_wr_tick), .ay_wdata(ay_wdata),
      .ay_rd_tick(ay_rd_tick), .ay_rdata(ay_rdata));

   ay_bus_master #(.FIFO_DEPTH(4), .GAP(3)) u_g3 (
      .clk(clk), .reset(reset), .cmd_valid(g3_cmd_valid), .cmd_ready(g3_cmd_ready),
      .cmd_rd(g3_cmd_rd), .cmd_addr(g3_cmd_addr), .cmd_data(g3_cmd_data),
      .rsp_valid(g3_rsp_valid), .rsp_data(g3_rsp_data), .busy(g3_busy),
      .ay_a0(g3_a0), .ay_wr_tick(g3_wr), .ay_wdata(g3_wdata),
      .ay_rd_tick(g3_rd), .ay_rdata(g3_rdata));

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Chip model: tracks the latched register; read data is only present in
   // the cycle after a read tick (r8 reads 0x0F, others read {A,reg}).
   logic [3:0] m_addr = 4'h0;
   always @(posedge clk) begin
      if (ay_wr_tick && !ay_a0) m_addr <= ay_wdata[3:0];
      if (ay_rd_tick) ay_rdata <= (m_addr == 4'h8) ? 8'h0F : {4'hA, m_addr};
      else            ay_rdata <= 8'h00;
   end

   // Tick monitor for the GAP=1 instance.
   int        wr_cnt = 0, rd_cnt = 0, spacing_err = 0, last_tick = -10;
   logic [7:0] data_q [$];
   always @(negedge clk) begin
      if (ay_wr_tick) wr_cnt <= wr_cnt + 1;
      if (ay_rd_tick) rd_cnt <= rd_cnt + 1;
      if (ay_wr_tick && ay_a0) data_q.push_back(ay_wdata);
      if (ay_wr_tick || ay_rd_tick) begin
         if ((cyc - last_tick < 2) || (ay_wr_tick && ay_rd_tick))
            spacing_err <= spacing_err + 1;
         last_tick <= cyc;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic       vld;
      logic       rd;
      logic [3:0] addr;
      logic [7:0] data;
      logic       e_wr;
      logic       e_rdt;
      logic       e_a0;
      logic [7:0] e_wdata;
      logic       e_rspv;
      logic [7:0] e_rspd;
      logic       e_busy;
      logic       e_rdy;
   } vec_t;

   vec_t vecs [15];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int k, base_wr, base_rd, base_dq, exp_cache;
      int t_a1, t_a2, t_d1, t_push;
      logic acc, saw_full;
      logic [21:0] act, exp;

      // write r7=0x38 then read r8 (cycle 0 = command accepted)
      //            vld  rd   addr  data   wr   rdt  a0   wdata  rspv rspd   busy rdy
      vecs[0]  = '{1'b1,1'b0,4'h7,8'h38, 1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0,1'b1};
      vecs[1]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1,1'b1};
      vecs[2]  = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,1'b0,8'h07, 1'b0,8'h00, 1'b1,1'b1};
      vecs[3]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,8'h07, 1'b0,8'h00, 1'b1,1'b1};
      vecs[4]  = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,1'b1,8'h38, 1'b0,8'h00, 1'b1,1'b1};
      vecs[5]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b1,8'h38, 1'b0,8'h00, 1'b1,1'b1};
      vecs[6]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b1,8'h38, 1'b0,8'h00, 1'b0,1'b1};
      vecs[7]  = '{1'b1,1'b1,4'h8,8'h00, 1'b0,1'b0,1'b1,8'h38, 1'b0,8'h00, 1'b0,1'b1};
      vecs[8]  = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b1,8'h38, 1'b0,8'h00, 1'b1,1'b1};
      vecs[9]  = '{1'b0,1'b0,4'h0,8'h00, 1'b1,1'b0,1'b0,8'h08, 1'b0,8'h00, 1'b1,1'b1};
      vecs[10] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b0,8'h08, 1'b0,8'h00, 1'b1,1'b1};
      vecs[11] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b1,1'b1,8'h08, 1'b0,8'h00, 1'b1,1'b1};
      vecs[12] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b1,8'h08, 1'b0,8'h00, 1'b1,1'b1};
      vecs[13] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b1,8'h08, 1'b1,8'h0F, 1'b1,1'b1};
      vecs[14] = '{1'b0,1'b0,4'h0,8'h00, 1'b0,1'b0,1'b1,8'h08, 1'b0,8'h0F, 1'b0,1'b1};

      reset = 1'b1;
      cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = 4'h0; cmd_data = 8'h00;
      g3_cmd_valid = 1'b0; g3_cmd_rd = 1'b0; g3_cmd_addr = 4'h0; g3_cmd_data = 8'h00;
      g3_rdata = 8'h00;
      repeat (3) @(posedge clk);

      // ---- table: write then read ----
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (i == 0) reset = 1'b0;
         cmd_valid = vecs[i].vld; cmd_rd = vecs[i].rd;
         cmd_addr  = vecs[i].addr; cmd_data = vecs[i].data;
         @(negedge clk);
         act = {ay_wr_tick, ay_rd_tick, ay_a0, ay_wdata, rsp_valid, rsp_data, busy, cmd_ready};
         exp = {vecs[i].e_wr, vecs[i].e_rdt, vecs[i].e_a0, vecs[i].e_wdata,
                vecs[i].e_rspv, vecs[i].e_rspd, vecs[i].e_busy, vecs[i].e_rdy};
         chk($sformatf("vec%0d {wr,rd,a0,wdata,rspv,rspd,busy,rdy}", i), 32'(act), 32'(exp));
      end

      // ---- burst of 8 writes with cmd_valid held ----
      base_wr = wr_cnt; base_dq = data_q.size();
      acc = 1'b0; saw_full = 1'b0; k = 0;
      for (int t = 0; t < 200 && k < 8; t++) begin
         @(posedge clk);
         if (acc) k++;
         #1;
         if (k < 8) begin
            cmd_valid = 1'b1; cmd_rd = 1'b0;
            cmd_addr = 4'(k); cmd_data = 8'(8'h10 + k);
         end else cmd_valid = 1'b0;
         @(negedge clk);
         acc = cmd_valid & cmd_ready;
         if (cmd_valid && !cmd_ready) saw_full = 1'b1;
      end
      cmd_valid = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk);
      chk("burst_accepted", 32'(k), 32'd8);
      chk("burst_saw_full", 32'(saw_full), 32'd1);
      chk("burst_wr_ticks", 32'(wr_cnt - base_wr), 32'd16);
      chk("burst_data_count", 32'(data_q.size() - base_dq), 32'd8);
      for (int i = 0; i < 8; i++)
         if (base_dq + i < data_q.size())
            chk($sformatf("burst_data%0d", i), 32'(data_q[base_dq + i]), 32'(8'h10 + i));
      chk("burst_spacing_err", 32'(spacing_err), 32'd0);
      chk("burst_busy_done", 32'(busy), 32'd0);

      // ---- two writes to the same register ----
`ifdef AY_ADDR_CACHE_EN
      exp_cache = 3;
`else
      exp_cache = 4;
`endif
      base_wr = wr_cnt; base_dq = data_q.size();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 4'h3; cmd_data = 8'hAA;
      @(posedge clk); #1;
      cmd_data = 8'h55;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("same_reg_wr_ticks", 32'(wr_cnt - base_wr), 32'(exp_cache));
      chk("same_reg_data_count", 32'(data_q.size() - base_dq), 32'd2);
      if (data_q.size() >= base_dq + 2) begin
         chk("same_reg_data0", 32'(data_q[base_dq]), 32'h0000_00AA);
         chk("same_reg_data1", 32'(data_q[base_dq + 1]), 32'h0000_0055);
      end
      chk("same_reg_spacing_err", 32'(spacing_err), 32'd0);

      // ---- reset in WAIT1 with two commands still queued ----
      base_wr = wr_cnt; base_rd = rd_cnt;
      @(posedge clk); #1;                        // c0
      cmd_valid = 1'b1; cmd_addr = 4'h1; cmd_data = 8'h11;
      @(posedge clk); #1;                        // c1
      cmd_addr = 4'h2; cmd_data = 8'h22;
      @(posedge clk); #1;                        // c2 (address tick)
      cmd_addr = 4'h4; cmd_data = 8'h44;
      @(negedge clk);
      chk("rst_addr_tick", 32'({ay_wr_tick, ay_a0, ay_wdata}), 32'({1'b1, 1'b0, 8'h01}));
      @(posedge clk); #1;                        // c3 = WAIT1
      cmd_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("rst_wait1_state", 32'({ay_wr_tick, busy}), 32'({1'b0, 1'b1}));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_after {busy,rdy,wr,rd,a0,wdata,rspv,rspd}",
          32'({busy, cmd_ready, ay_wr_tick, ay_rd_tick, ay_a0, ay_wdata, rsp_valid, rsp_data}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00}));
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("rst_total_wr_ticks", 32'(wr_cnt - base_wr), 32'd1);
      chk("rst_total_rd_ticks", 32'(rd_cnt - base_rd), 32'd0);
      chk("rst_idle_busy", 32'(busy), 32'd0);

      // ---- GAP=3 instance, two writes ----
      t_a1 = -1; t_a2 = -1; t_d1 = -1;
      @(posedge clk); #1;
      t_push = cyc;
      g3_cmd_valid = 1'b1; g3_cmd_addr = 4'h1; g3_cmd_data = 8'h11;
      @(posedge clk); #1;
      g3_cmd_addr = 4'h2; g3_cmd_data = 8'h22;
      @(posedge clk); #1;
      g3_cmd_valid = 1'b0;
      for (int t = 0; t < 60 && t_a2 < 0; t++) begin
         @(negedge clk);
         if (g3_wr && !g3_a0) begin
            if (t_a1 < 0) t_a1 = cyc; else t_a2 = cyc;
         end
         if (g3_wr && g3_a0 && t_d1 < 0) t_d1 = cyc;
      end
      chk("g3_addr_latency", 32'(t_a1 - t_push), 32'd2);
      chk("g3_addr_to_data", 32'(t_d1 - t_a1), 32'd4);
      chk("g3_data_to_next_addr_ge4", 32'((t_a2 >= 0) && (t_a2 - t_d1 >= 4)), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ay_bus_master.md
Name: ay_bus_master

Overview:
- Bus initiator that drives the AY-style two-step register interface (address latch, then data transfer) from a queued command stream.
- Accepts register write and read commands through a valid/ready port, buffers them in a small FIFO and sequences the a0/wr_tick/rd_tick strobes with programmable spacing.
- Returns read data on a response strobe.
- Sits between a CPU I/O decoder or autonomous music player and the sound generator.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- GAP, 1, idle cycles inserted after every tick; minimum 1.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept a command; equals not-full.
- cmd_rd  input  1  1=read register, 0=write register.
- cmd_addr  input  4  register number 0-15.
- cmd_data  input  8  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse; rsp_data is valid.
- rsp_data  output  8  read result; held until the next response.
- busy  output  1  FIFO non-empty or sequencer not IDLE.
- ay_a0  output  1  0=address latch, 1=data transfer.
- ay_wr_tick  output  1  one-cycle write strobe.
- ay_wdata  output  8  write data; stable while ay_wr_tick is high.
- ay_rd_tick  output  1  one-cycle read strobe.
- ay_rdata  input  8  valid in the cycle after ay_rd_tick.

Behaviour:
- Reset (synchronous, active-high) forces:
  - all outputs to 0 except cmd_ready=1;
  - FIFO empty, state IDLE;
  - rsp_data=0x00, gap counter 0;
  - address cache invalid.
- Reset mid-sequence aborts the sequence: no further tick is issued for the aborted command.
- Push: cmd_valid & cmd_ready pushes {cmd_rd, cmd_addr, cmd_data}.
- Pop: occurs only in IDLE with FIFO non-empty.
- A push and a pop in the same cycle are legal; the occupancy count is unchanged.
- At FIFO_DEPTH entries cmd_ready=0, and a pop in that cycle does not raise cmd_ready until the next cycle.
- Commands are issued strictly in order. No command is dropped or duplicated.
- States and transitions:
  - IDLE: if non-empty, pop into the command register -> ADDR.
  - ADDR: ay_a0=0, ay_wr_tick=1, ay_wdata={4'h0,addr} -> WAIT1.
  - WAIT1: GAP cycles, all ticks low -> XFER.
  - XFER, write: ay_a0=1, ay_wr_tick=1, ay_wdata=data -> WAIT2.
  - XFER, read: ay_a0=1, ay_rd_tick=1 -> CAPT.
  - CAPT: sample ay_rdata into rsp_data. rsp_valid=1 in the following cycle -> WAIT2.
  - WAIT2: GAP cycles -> IDLE.
- ay_a0 and ay_wdata hold their last values between ticks.
- Never assert ay_wr_tick and ay_rd_tick in the same cycle.
- Never assert two ticks in consecutive cycles.
- Latency, GAP=1, FIFO empty, command accepted in cycle 0:
  - pop in cycle 1;
  - address tick in cycle 2;
  - data/read tick in cycle 4;
  - for reads: CAPT in cycle 5, rsp_valid in cycle 6;
  - next pop no earlier than cycle 6 (write) or cycle 7 (read).
- rsp_valid has no backpressure; the consumer must take it.
- busy falls in the cycle the sequencer returns to IDLE with the FIFO empty.

Optional Feature:
- Macro: AY_ADDR_CACHE_EN.
- When defined:
  - The last latched address is kept together with a valid flag.
  - A popped command whose addr equals the cached address skips ADDR and WAIT1 and goes straight from IDLE to XFER.
  - The cache is set on every ADDR tick and cleared by reset.
- When undefined: every command issues an ADDR tick.

Test Plan:
- Write r7=0x38 from idle (GAP=1) -> cycle 2: wr_tick, a0=0, wdata=0x07. Cycle 4: wr_tick, a0=1, wdata=0x38. Exactly 2 ticks; busy low by cycle 6.
- Read r8 with the bench model driving ay_rdata=0x0F the cycle after rd_tick -> one rd_tick at cycle 4 with a0=1. rsp_valid single pulse at cycle 6, rsp_data=0x0F, no wr_tick at cycle 4.
- cmd_valid held high for 8 writes (regs 0-7, data 0x10-0x17) -> cmd_ready drops once the FIFO is full. All 8 accepted, 16 wr_ticks total, data order 0x10..0x17, consecutive ticks always ≥2 cycles apart.
- Reset asserted in the WAIT1 cycle of a write to r1 with 2 more commands queued -> no data tick afterwards, busy=0 and cmd_ready=1 the cycle after reset, no ticks while idle.
- Two writes to r3 (0xAA, 0x55): with AY_ADDR_CACHE_EN -> 3 wr_ticks (addr, 0xAA, 0x55); without it -> 4 wr_ticks.
- GAP=3, single write -> address tick and data tick 4 cycles apart; the next command's address tick ≥4 cycles after the data tick.
